// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//
// Divides the system clock into a step tick and drives N_LEDS outputs with one
// of four patterns: binary up, binary down, one-hot chase or ping-pong bounce.
// Pause, run-time mode switching and a wrap flag are built in.
//
// Optional feature macro: LED_SEQ_PWM_EN
//   When defined, a free-running PWM_BITS counter gates the LED drive with a
//   duty of brightness/2^PWM_BITS. When undefined, leds is the pattern register
//   and brightness is ignored.
//
// Parameters:
//   CLK_HZ    input clock frequency in Hz
//   STEP_HZ   pattern step rate in Hz; DIV = CLK_HZ/STEP_HZ must be >= 2
//   N_LEDS    number of LED outputs, must be >= 2
//   PWM_BITS  width of the brightness control
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   mode        pattern select: 0 up, 1 down, 2 chase, 3 bounce
//   pause       hold the divider and the pattern while high
//   brightness  duty control (PWM build only)
//   leds        LED drive
//   step        one-cycle pulse when a new pattern value first appears
//   wrap        one-cycle pulse, with step, when the pattern returns to start
//
// Handshake: none. All inputs are level-sampled on every rising clock edge;
// step and wrap are registered single-cycle pulses.
// -----------------------------------------------------------------------------
module led_sequencer #(
    parameter int CLK_HZ   = 12000000,
    parameter int STEP_HZ  = 1,
    parameter int N_LEDS   = 4,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                pause,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [N_LEDS-1:0]   leds,
    output logic                step,
    output logic                wrap
);

    localparam int DIV   = CLK_HZ / STEP_HZ;
    // Keep the divider at least one bit wide so DIV == 2 still elaborates.
    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    // Pattern each mode starts from (and wraps back to).
    function automatic logic [N_LEDS-1:0] start_value(input mode_e m);
        logic [N_LEDS-1:0] v;
        case (m)
            MODE_UP:   v = '0;
            MODE_DOWN: v = '1;
            default:   v = {{(N_LEDS-1){1'b0}}, 1'b1};
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // State registers and next-state values
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [N_LEDS-1:0] pattern_q, pattern_d;
    mode_e             mode_q,    mode_d;
    logic              dir_q,     dir_d;
    logic              step_q,    step_d;
    logic              wrap_q,    wrap_d;

    mode_e mode_in;
    assign mode_in = mode_e'(mode);

    // Priority below reset: mode change > pause > tick > divider count.
    always_comb begin
        mode_d    = mode_q;
        div_d     = div_q;
        pattern_d = pattern_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        wrap_d    = 1'b0;

        if (mode_in != mode_q) begin
            // Restart cleanly in the new mode; a coincident tick is dropped.
            mode_d    = mode_in;
            div_d     = '0;
            pattern_d = start_value(mode_in);
            dir_d     = DIR_LEFT;
        end else if (pause) begin
            // Everything holds; step/wrap default to 0.
        end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            step_d = 1'b1;
            case (mode_q)
                MODE_UP:    pattern_d = pattern_q + N_LEDS'(1);
                MODE_DOWN:  pattern_d = pattern_q - N_LEDS'(1);
                MODE_CHASE: pattern_d = {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};
                default: begin
                    // Bounce: direction flips on the step that lands on an end.
                    if (dir_q == DIR_LEFT) begin
                        pattern_d = pattern_q << 1;
                        if (pattern_d[N_LEDS-1]) begin
                            dir_d = DIR_RIGHT;
                        end
                    end else begin
                        pattern_d = pattern_q >> 1;
                        if (pattern_d[0]) begin
                            dir_d = DIR_LEFT;
                        end
                    end
                end
            endcase
            wrap_d = (pattern_d == start_value(mode_q));
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // A mode change coincident with reset is absorbed here.
            mode_q    <= mode_in;
            div_q     <= '0;
            pattern_q <= start_value(mode_in);
            dir_q     <= DIR_LEFT;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            div_q     <= div_d;
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            wrap_q    <= wrap_d;
        end
    end

    assign step = step_q;
    assign wrap = wrap_q;

    // ------------------------------------------------------------------------
    // LED drive
    // ------------------------------------------------------------------------
`ifdef LED_SEQ_PWM_EN
    logic [PWM_BITS-1:0] pwm_q;
    logic                rst_seen_q;   // blanks leds in the cycle after a reset edge
    logic                pwm_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q      <= '0;
            rst_seen_q <= 1'b1;
        end else begin
            pwm_q      <= pwm_q + PWM_BITS'(1);
            rst_seen_q <= 1'b0;
        end
    end

    // pwm < brightness: 0 gives always off, max gives (2^P-1)/2^P duty.
    assign pwm_on = (pwm_q < brightness);
    assign leds   = rst_seen_q ? '0 : (pattern_q & {N_LEDS{pwm_on}});
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign leds = pattern_q;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_sequencer
//
// Directed scenarios plus a randomized run of led_sequencer with DIV=8, N=4.
// The reference model tracks only the current mode, the cycle position within
// the step interval and the number of steps taken; the expected pattern is
// computed arithmetically from the step count.
// -----------------------------------------------------------------------------
module tb_led_sequencer;

  localparam int CLK_HZ   = 8;
  localparam int STEP_HZ  = 1;
  localparam int N_LEDS   = 4;
  localparam int PWM_BITS = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          mode = 2'd0;
  logic                pause = 1'b0;
  logic [PWM_BITS-1:0] brightness = '1;
  logic [N_LEDS-1:0]   leds;
  logic                step;
  logic                wrap;

  always #5 clk = ~clk;

  led_sequencer #(
    .CLK_HZ  (CLK_HZ),
    .STEP_HZ (STEP_HZ),
    .N_LEDS  (N_LEDS),
    .PWM_BITS(PWM_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .pause     (pause),
    .brightness(brightness),
    .leds      (leds),
    .step      (step),
    .wrap      (wrap)
  );

  int checks = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int   m_mode = 0;
  int   m_cnt = 0;    // cycles elapsed in the current step interval
  int   m_k = 0;      // steps taken since the last restart
  logic m_step = 1'b0;
  logic m_wrap = 1'b0;
  int   m_pwm = 0;
  logic m_rst_seen = 1'b1;

  logic [N_LEDS-1:0] exp_q[$];

  function automatic int period(input int md);
    case (md)
      0, 1:    return 16;
      2:       return 4;
      default: return 6;
    endcase
  endfunction

  function automatic logic [N_LEDS-1:0] model_pattern(input int md, input int k);
    int p;
    int pos;
    case (md)
      0: return 4'(k % 16);
      1: return 4'(15 - (k % 16));
      2: return 4'(1 << (k % 4));
      default: begin
        p   = k % 6;
        pos = (p <= 3) ? p : 6 - p;
        return 4'(1 << pos);
      end
    endcase
  endfunction

  function automatic logic [N_LEDS-1:0] exp_leds();
`ifdef LED_SEQ_PWM_EN
    if (m_rst_seen) return '0;
    if (m_pwm >= int'(brightness)) return '0;
`endif
    return model_pattern(m_mode, m_k);
  endfunction

  // Advance one clock: update the model from the inputs seen at the edge,
  // then settle 1 time unit so DUT outputs can be sampled.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_mode = int'(mode); m_cnt = 0; m_k = 0; m_step = 0; m_wrap = 0;
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_cnt = 0; m_k = 0; m_step = 0; m_wrap = 0;
    end else if (pause) begin
      m_step = 0; m_wrap = 0;
    end else if (m_cnt == CLK_HZ / STEP_HZ - 1) begin
      m_cnt = 0; m_k++; m_step = 1;
      m_wrap = ((m_k % period(m_mode)) == 0);
    end else begin
      m_cnt++; m_step = 0; m_wrap = 0;
    end
    m_pwm      = rst ? 0 : (m_pwm + 1) % 16;
    m_rst_seen = rst;
    #1;
  endtask

  task automatic apply_reset(input logic [1:0] md);
    rst = 1'b1; mode = md; pause = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; mode = 2'd0; pause = 1'b0;
    tick();
    tick();
    checks++;
    if ({leds, step, wrap} !== 6'b0000_00) begin
      failures++;
      $display("FAIL reset_state: got leds=%b step=%b wrap=%b, want 0000 0 0", leds, step, wrap);
    end
  endtask

  task automatic test_up_count();
    int first_step;
    first_step = -1;
    rst = 1'b0;
    for (int i = 1; i <= 16 * 8; i++) begin
      tick();
      checks++;
      if ({leds, step, wrap} !== {exp_leds(), m_step, m_wrap}) begin
        failures++;
        $display("FAIL up_cycle%0d: got %b/%b/%b want %b/%b/%b", i, leds, step, wrap,
                 exp_leds(), m_step, m_wrap);
      end
      if (step && first_step < 0) first_step = i;
    end
    checks++;
    if (first_step !== 8) begin
      failures++;
      $display("FAIL up_first_step: got cycle %0d want 8", first_step);
    end
    checks++;
    if ({step, wrap} !== 2'b11) begin
      failures++;
      $display("FAIL up_wrap16: got step=%b wrap=%b want 1 1", step, wrap);
    end
`ifndef LED_SEQ_PWM_EN
    checks++;
    if (leds !== 4'b0000) begin
      failures++;
      $display("FAIL up_wrap_leds: got %b want 0000", leds);
    end
`endif
  endtask

  task automatic test_bounce();
    logic [3:0] seq [12];
    int n;
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
            4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    n = 0;
    apply_reset(2'd3);
    for (int i = 1; i <= 12 * 8; i++) begin
      tick();
      checks++;
      if ({leds, step, wrap} !== {exp_leds(), m_step, m_wrap}) begin
        failures++;
        $display("FAIL bounce_cycle%0d: got %b/%b/%b want %b/%b/%b", i, leds, step, wrap,
                 exp_leds(), m_step, m_wrap);
      end
      if (step && n < 12) begin
        checks++;
        if (wrap !== ((n % 6) == 5)) begin
          failures++;
          $display("FAIL bounce_wrap_step%0d: got %b want %b", n + 1, wrap, (n % 6) == 5);
        end
`ifndef LED_SEQ_PWM_EN
        checks++;
        if (leds !== seq[n]) begin
          failures++;
          $display("FAIL bounce_seq_step%0d: got %b want %b", n + 1, leds, seq[n]);
        end
`endif
        n++;
      end
    end
  endtask

  task automatic test_pause();
    int since;
    apply_reset(2'd0);
    for (int i = 0; i < 16; i++) tick();  // two steps: pattern 0010
    for (int i = 0; i < 3; i++) tick();   // divider now at 3
    since = 3;
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      since++;
      checks++;
      if ({leds, step, wrap} !== {exp_leds(), 2'b00}) begin
        failures++;
        $display("FAIL pause_hold%0d: got %b/%b/%b want %b/0/0", i, leds, step, wrap, exp_leds());
      end
    end
    pause = 1'b0;
    for (int i = 0; i < 20 && !step; i++) begin
      tick();
      since++;
    end
    checks++;
    if (since !== 13 || step !== 1'b1) begin
      failures++;
      $display("FAIL pause_stretch: got step after %0d cycles (step=%b) want 13", since, step);
    end
  endtask

  task automatic test_mode_switch();
    int since;
    apply_reset(2'd0);
    for (int i = 0; i < 40 + 3; i++) tick();  // pattern 0101, mid-interval
    mode = 2'd2;
    tick();
    checks++;
    if ({leds, step, wrap} !== {exp_leds(), 2'b00} || model_pattern(2, 0) !== 4'b0001) begin
      failures++;
      $display("FAIL mode_switch_now: got %b/%b/%b want %b/0/0", leds, step, wrap, exp_leds());
    end
`ifndef LED_SEQ_PWM_EN
    checks++;
    if (leds !== 4'b0001) begin
      failures++;
      $display("FAIL mode_switch_leds: got %b want 0001", leds);
    end
`endif
    since = 0;
    for (int i = 0; i < 20 && !step; i++) begin
      tick();
      since++;
    end
    checks++;
    if (since !== 8 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL mode_switch_next: got step after %0d cycles wrap=%b want 8 0", since, wrap);
    end
`ifndef LED_SEQ_PWM_EN
    checks++;
    if (leds !== 4'b0010) begin
      failures++;
      $display("FAIL mode_switch_next_leds: got %b want 0010", leds);
    end
`endif
  endtask

  task automatic test_switch_and_tick();
    apply_reset(2'd1);
    for (int i = 0; i < 7; i++) tick();  // divider at 7
    mode = 2'd3;
    tick();
    checks++;
    if ({step, wrap} !== 2'b00) begin
      failures++;
      $display("FAIL switch_tick_step: got step=%b wrap=%b want 0 0", step, wrap);
    end
`ifndef LED_SEQ_PWM_EN
    checks++;
    if (leds !== 4'b0001) begin
      failures++;
      $display("FAIL switch_tick_leds: got %b want 0001", leds);
    end
`endif
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({leds, step, wrap} !== {exp_leds(), m_step, m_wrap}) begin
        failures++;
        $display("FAIL switch_tick_after%0d: got %b/%b/%b want %b/%b/%b", i, leds, step, wrap,
                 exp_leds(), m_step, m_wrap);
      end
    end
  endtask

  task automatic test_random();
    logic [N_LEDS-1:0] want;
    apply_reset(2'($urandom_range(0, 3)));
    exp_q.delete();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      pause = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) brightness = PWM_BITS'($urandom_range(0, 15));
      tick();
      if (m_step) exp_q.push_back(exp_leds());
      checks++;
      if ({leds, step, wrap} !== {exp_leds(), m_step, m_wrap}) begin
        failures++;
        $display("FAIL random_cycle%0d: got %b/%b/%b want %b/%b/%b", i, leds, step, wrap,
                 exp_leds(), m_step, m_wrap);
      end
      if (step) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL random_unexpected_step%0d: got step=1 want no step", i);
        end else begin
          want = exp_q.pop_front();
          if (leds !== want) begin
            failures++;
            $display("FAIL random_step_leds%0d: got %b want %b", i, leds, want);
          end
        end
      end
    end
    rst = 1'b0;
    pause = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_missing_steps: got %0d unmatched, want 0", exp_q.size());
    end
  endtask

`ifdef LED_SEQ_PWM_EN
  task automatic test_pwm();
    int on_cnt;
    brightness = 4'd4;
    apply_reset(2'd2);
    pause = 1'b1;   // freeze the pattern at 0001; PWM keeps running
    on_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (leds[0]) on_cnt++;
    end
    checks++;
    if (on_cnt !== 8) begin
      failures++;
      $display("FAIL pwm_duty4: got %0d of 32 cycles lit want 8", on_cnt);
    end
    brightness = 4'd0;
    on_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (leds != 4'b0000) on_cnt++;
    end
    checks++;
    if (on_cnt !== 0) begin
      failures++;
      $display("FAIL pwm_off: got %0d lit cycles want 0", on_cnt);
    end
    brightness = 4'd15;
    pause = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({leds, step} !== 5'b0000_0) begin
      failures++;
      $display("FAIL pwm_reset: got leds=%b step=%b want 0000 0", leds, step);
    end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_up_count();
    test_bounce();
    test_pause();
    test_mode_switch();
    test_switch_and_tick();
`ifdef LED_SEQ_PWM_EN
    test_pwm();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, want finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
